// File: rtl/constant_encoder.sv
// constant_encoder
//   Splits a 32-bit constant into the shortest sequence of 15-bit immediate /
//   extension-select beats for the constant-extension unit. A constant that
//   fits one immediate (sign- or zero-extended) takes one beat. Any other
//   constant takes three zero-fill beats carrying 2 + 15 + 15 bits.
//   A downstream accumulate-by-shift consumer rebuilds the original word.
//
// Ports
//   CLK       : clock, rising edge
//   RST_N     : asynchronous active-low reset
//   IN_VALID  : VALUE is presented
//   IN_READY  : block can accept a constant (IDLE only)
//   VALUE     : 32-bit constant to encode
//   OUT_VALID : IM/CS/FIRST/LAST hold a valid beat
//   OUT_READY : consumer takes the beat this cycle
//   IM        : 15-bit immediate field
//   CS        : 1 = sign-extend, 0 = zero-fill
//   FIRST     : beat starts a new constant
//   LAST      : final beat of the constant
//   WIDE_CNT  : saturating count of constants that needed three beats
module constant_encoder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] VALUE,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [14:0] IM,
  output logic        CS,
  output logic        FIRST,
  output logic        LAST,
  output logic [15:0] WIDE_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    SHORT,
    W0,
    W1,
    W2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Only bits [29:0] are needed after the accept beat; [31:30] go out in W0
  // straight from VALUE.
  logic [29:0] r_value;
  logic [29:0] w_value_nxt;

  logic        r_out_valid;
  logic        w_out_valid_nxt;
  logic [14:0] r_im;
  logic [14:0] w_im_nxt;
  logic        r_cs;
  logic        w_cs_nxt;
  logic        r_first;
  logic        w_first_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic [15:0] r_wide_cnt;

  logic        w_sign_fit;
  logic        w_zero_fit;
  logic        w_xfer;
  logic        w_wide_inc;

  assign w_sign_fit = (VALUE[31:14] == '0) || (VALUE[31:14] == '1);
  assign w_zero_fit = (VALUE[31:15] == '0);
  assign w_xfer     = r_out_valid && OUT_READY;

  // Next-state and next-beat decode. Beat fields are computed one cycle
  // ahead so every output comes straight from a register; with no transfer
  // everything holds, which keeps the beat stable under backpressure.
  always_comb begin
    w_state_nxt     = r_state;
    w_value_nxt     = r_value;
    w_out_valid_nxt = r_out_valid;
    w_im_nxt        = r_im;
    w_cs_nxt        = r_cs;
    w_first_nxt     = r_first;
    w_last_nxt      = r_last;
    w_wide_inc      = 1'b0;

    case (r_state)
      IDLE: begin
        if (IN_VALID) begin
          w_value_nxt     = VALUE[29:0];
          w_out_valid_nxt = 1'b1;
          w_first_nxt     = 1'b1;
          if (w_sign_fit || w_zero_fit) begin
            // Sign-fit wins when both hold (values 0..0x3FFF).
            w_state_nxt = SHORT;
            w_im_nxt    = VALUE[14:0];
            w_cs_nxt    = w_sign_fit;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = W0;
            w_im_nxt    = {13'b0, VALUE[31:30]};
            w_cs_nxt    = 1'b0;
            w_last_nxt  = 1'b0;
            w_wide_inc  = 1'b1;
          end
        end
      end

      W0: begin
        if (w_xfer) begin
          w_state_nxt = W1;
          w_im_nxt    = r_value[29:15];
          w_first_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end

      W1: begin
        if (w_xfer) begin
          w_state_nxt = W2;
          w_im_nxt    = r_value[14:0];
          w_last_nxt  = 1'b1;
        end
      end

      SHORT, W2: begin
        if (w_xfer) begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b0;
          w_im_nxt        = '0;
          w_cs_nxt        = 1'b0;
          w_first_nxt     = 1'b0;
          w_last_nxt      = 1'b0;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
        w_im_nxt        = '0;
        w_cs_nxt        = 1'b0;
        w_first_nxt     = 1'b0;
        w_last_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_value     <= '0;
      r_out_valid <= 1'b0;
      r_im        <= '0;
      r_cs        <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_value     <= w_value_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_im        <= w_im_nxt;
      r_cs        <= w_cs_nxt;
      r_first     <= w_first_nxt;
      r_last      <= w_last_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wide_cnt <= '0;
    end else if (w_wide_inc && (r_wide_cnt != '1)) begin
      r_wide_cnt <= r_wide_cnt + 16'd1;
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = r_out_valid;
  assign IM        = r_im;
  assign CS        = r_cs;
  assign FIRST     = r_first;
  assign LAST      = r_last;
  assign WIDE_CNT  = r_wide_cnt;

endmodule
